// File: rtl/linear_counter_pkg.sv
// Shared constants for the linear counter: default counter width and the count value after reset.
package linear_counter_pkg;

  localparam int DEFAULT_WIDTH = 7;
  localparam int COUNT_RESET_VALUE = 0;

endpackage

// File: rtl/linear_counter.sv
// Linear counter: reload/halt flag with a saturating countdown, one tick per clk edge.
// Latency: one edge from any input to linearCounterOut; no backpressure, every edge is a tick.
// LINEAR_COUNTER_ZERO_FLAG_EN adds the combinational linearCounterZero output.
module linear_counter
  import linear_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             setHaltFlag,
  input  logic             controlFlag,
  input  logic [WIDTH-1:0] counterReloadValue,
  output logic [WIDTH-1:0] linearCounterOut
`ifdef LINEAR_COUNTER_ZERO_FLAG_EN
  ,
  output logic             linearCounterZero
`endif
);

  logic [WIDTH-1:0] count;
  logic             reloadFlag;

  // A pending reload wins over the countdown; controlFlag decides whether it persists.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= WIDTH'(COUNT_RESET_VALUE);
      reloadFlag <= 1'b0;
    end else if (setHaltFlag) begin
      count      <= counterReloadValue;
      reloadFlag <= 1'b1;
    end else if (reloadFlag) begin
      count      <= counterReloadValue;
      reloadFlag <= controlFlag;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign linearCounterOut = count;

`ifdef LINEAR_COUNTER_ZERO_FLAG_EN
  assign linearCounterZero = (count == '0);
`endif

endmodule

// File: tb/tb_linear_counter.sv
// Bench for linear_counter: directed scenarios with fixed expectations plus randomized ticks against a reference model.
module tb_linear_counter;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         setHaltFlag = 1'b0;
  logic         controlFlag = 1'b0;
  logic [W-1:0] counterReloadValue = '0;
  logic [W-1:0] linearCounterOut;
`ifdef LINEAR_COUNTER_ZERO_FLAG_EN
  logic         linearCounterZero;
`endif

  int numChecks = 0;
  int numFails = 0;

  // Reference state: value the counter should show and whether a reload is still owed.
  int mCount = 0;
  bit mReloadPending = 0;

  always #5 clk = ~clk;

  linear_counter #(.WIDTH(W)) dut (
    .clk                (clk),
    .reset              (reset),
    .setHaltFlag        (setHaltFlag),
    .controlFlag        (controlFlag),
    .counterReloadValue (counterReloadValue),
    .linearCounterOut   (linearCounterOut)
`ifdef LINEAR_COUNTER_ZERO_FLAG_EN
    ,
    .linearCounterZero  (linearCounterZero)
`endif
  );

  task automatic checkVal(input string tag, input int actual, input int expected);
    numChecks++;
    if (actual != expected) begin
      numFails++;
      $display("FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Apply inputs for one edge, advance the model, and compare just after the edge.
  task automatic tick(input bit r, input bit s, input bit c, input int v);
    reset = r;
    setHaltFlag = s;
    controlFlag = c;
    counterReloadValue = W'(v);
    @(posedge clk);
    #1;
    if (r) begin
      mCount = 0;
      mReloadPending = 0;
    end else if (s) begin
      mCount = v;
      mReloadPending = 1;
    end else if (mReloadPending) begin
      mCount = v;
      mReloadPending = c;
    end else begin
      mCount = (mCount > 0) ? mCount - 1 : 0;
    end
    checkVal("model", int'(linearCounterOut), mCount);
`ifdef LINEAR_COUNTER_ZERO_FLAG_EN
    checkVal("zeroModel", int'(linearCounterZero), int'(mCount == 0));
`endif
  endtask

  task automatic expectOut(input string tag, input int expected);
    checkVal(tag, int'(linearCounterOut), expected);
  endtask

  initial begin
    // Reset, then idle: output stays at zero.
    tick(1, 0, 0, 0);
    expectOut("reset", 0);
`ifdef LINEAR_COUNTER_ZERO_FLAG_EN
    checkVal("zeroAtReset", int'(linearCounterZero), 1);
`endif
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0);
      expectOut("idleZero", 0);
    end

    // Load 10, flag clears on the reload tick, then count down and hold.
    tick(0, 1, 0, 10);
    expectOut("loadTen", 10);
    tick(0, 0, 0, 10);
    expectOut("reloadTick", 10);
    for (int e = 9; e >= 0; e--) begin
      tick(0, 0, 0, 10 + e);  // later reload values must not disturb the countdown
      expectOut("countdown", e);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 10);
      expectOut("holdZero", 0);
    end

    // controlFlag keeps the reload flag set: output held at the reload value.
    tick(0, 1, 0, 10);
    for (int i = 0; i < 50; i++) begin
      tick(0, 0, 1, 10);
      expectOut("heldTen", 10);
    end

    // Mid-countdown re-trigger with a smaller reload value.
    tick(0, 0, 0, 10);
    for (int e = 9; e >= 6; e--) begin
      tick(0, 0, 0, 10);
      expectOut("toSix", e);
    end
    tick(0, 1, 0, 3);
    expectOut("retrigThree", 3);
    begin
      int seq[5] = '{3, 2, 1, 0, 0};
      for (int i = 0; i < 5; i++) begin
        tick(0, 0, 0, 3);
        expectOut("afterRetrig", seq[i]);
      end
    end

    // Reset beats a simultaneous setHaltFlag; nothing reloads afterwards.
    tick(0, 1, 1, 20);
    tick(1, 1, 1, 50);
    expectOut("resetOverSet", 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1, 50);
      expectOut("noReloadAfterReset", 0);
    end

    // Reload of zero loads zero and stays there.
    tick(0, 1, 0, 0);
    expectOut("loadZero", 0);
    tick(0, 0, 0, 9);
    expectOut("zeroReloadTick", 9);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    expectOut("zeroHeld", 0);

`ifdef LINEAR_COUNTER_ZERO_FLAG_EN
    tick(0, 1, 0, 5);
    checkVal("zeroFlagAtFive", int'(linearCounterZero), 0);
`endif
    tick(0, 1, 0, 127);
    expectOut("maxLoad", 127);
    tick(0, 0, 0, 127);
    tick(0, 0, 0, 127);
    expectOut("maxDecrement", 126);

    // Randomized ticks against the model.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom), int'($urandom_range(0, 127)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/linear_counter.md
LINEAR_COUNTER -- requirements
Module: linear_counter

Interface
REQ-001 Parameter: WIDTH, default 7, bit width of counter, reload value and output.
REQ-002 Port: clk  input  1  sole clock; every rising edge is one linear-counter tick (quarter-frame rate).
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: setHaltFlag  input  1  level request to set the internal reload (halt) flag and load the counter.
REQ-005 Port: controlFlag  input  1  when high, keeps the reload flag set after a reload tick; when low, the flag clears.
REQ-006 Port: counterReloadValue  input  WIDTH  value loaded into the counter on reload.
REQ-007 Port: linearCounterOut  output  WIDTH  current registered counter value.
REQ-008 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-009 State: WIDTH-bit register count (drives linearCounterOut directly) and 1-bit register reloadFlag.
REQ-010 Each rising clk edge, priority: reset, then setHaltFlag, then reloadFlag, then decrement.
REQ-011 If setHaltFlag=1: count <= counterReloadValue; reloadFlag <= 1 (controlFlag ignored that tick).
REQ-012 Else if reloadFlag=1: count <= counterReloadValue; reloadFlag <= controlFlag.
REQ-013 Else if count != 0: count <= count - 1; reloadFlag stays 0.
REQ-014 Else count holds at 0; no wrap-around below zero.
REQ-015 counterReloadValue SHALL be sampled on the tick the load occurs; later changes affect only later reload ticks.
REQ-016 Reload value 0 loads 0; count then holds 0 once reloadFlag clears.
REQ-017 With controlFlag=1 and reloadFlag set, count SHALL reload every tick indefinitely (held at reload value).
REQ-018 linearCounterOut SHALL change only on rising clk edges; latency one edge from input to output.

Reset
REQ-019 reset=1 at a rising edge SHALL force count=0 and reloadFlag=0, overriding setHaltFlag.
REQ-020 Reset mid-countdown SHALL abort it; after release, count stays 0 until the next setHaltFlag.

Configuration
REQ-021 Macro LINEAR_COUNTER_ZERO_FLAG_EN: when defined, an extra output linearCounterZero (1 bit) SHALL be present, equal to (count == 0), combinational from the register; 1 during and after reset.
REQ-022 Without LINEAR_COUNTER_ZERO_FLAG_EN the port SHALL be absent; all other behaviour is identical.

Structure
REQ-023 Shared package holds the default WIDTH constant (7) and the count reset value (0).
REQ-024 Single flat module; no sub-module is required.

Verification
REQ-025 Reset=1 one edge, then release with setHaltFlag=0 -> linearCounterOut=0 and stays 0 for 20 edges.
REQ-026 setHaltFlag=1, controlFlag=0, reload=10 for one edge, then setHaltFlag=0 -> out=10, 10 (reload tick clears flag), 9, 8, ..., 0, then holds 0.
REQ-027 setHaltFlag=1, reload=10 one edge, then setHaltFlag=0, controlFlag=1 -> out=10 held for 50 edges.
REQ-028 Countdown from 10 reaches 6, then controlFlag=0, setHaltFlag pulse with reload=3 -> out=3, 3, 2, 1, 0, 0.
REQ-029 reset asserted with setHaltFlag=1 at the same edge -> out=0 and no later reload without a new setHaltFlag.
REQ-030 With LINEAR_COUNTER_ZERO_FLAG_EN: linearCounterZero=1 at out=0 and 0 at out=5; reload=127 (WIDTH=7) -> out=127 with no overflow.
